commit_unit: RTL and testbench

COMMIT_UNIT -- requirements
Module: commit_unit

---
 rtl/commit_unit.sv | 174 +++++++++++++++++
 tb/tb_commit_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : commit_unit
//  Description : In-order commit stage. Buffers execute results in a small
//                FIFO, retires the head every cycle while running, writes the
//                register file, reports exceptions and requests a pipeline
//                flush that is held until the front end acknowledges it.
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_target_id,
    input  logic [31:0] in_value,
    input  logic        in_wen,
    input  logic        in_exc,
    input  logic [4:0]  in_exc_code,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        flush,
    input  logic        flush_ack,
    output logic [31:0] commit_count
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0]   c_cnt_one  = (c_aw+1)'(1);
    localparam logic [c_aw:0]   c_cnt_full = (c_aw+1)'(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  id;
        logic [31:0] value;
        logic        wen;
        logic        exc;
        logic [4:0]  exc_code;
    } entry_t;

    state_t          state_q, state_d;
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]   cnt_q, cnt_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [31:0]     rf_wdata_q, rf_wdata_d;
    logic            exc_valid_q, exc_valid_d;
    logic [4:0]      exc_code_q, exc_code_d;
    logic [31:0]     exc_pc_q, exc_pc_d;
    logic [31:0]     commit_count_q, commit_count_d;

    entry_t          fifo_mem [DEPTH];
    entry_t          head;
    logic            push;
    logic            discard;

    assign in_ready     = (state_q == ST_RUN) && (cnt_q < c_cnt_full);
    assign push         = in_valid && in_ready;
    assign head         = fifo_mem[rd_ptr_q];
    assign flush        = (state_q == ST_FLUSH);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign exc_valid    = exc_valid_q;
    assign exc_code     = exc_code_q;
    assign exc_pc       = exc_pc_q;
    assign commit_count = commit_count_q;

    // Entry storage; needs no reset because occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{pc: in_pc, id: in_target_id, value: in_value,
                                    wen: in_wen, exc: in_exc, exc_code: in_exc_code};
        end
    end

    // Next-state: retire head, handle faults, accept new entries, leave flush.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        cnt_d          = cnt_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        exc_valid_d    = 1'b0;
        exc_code_d     = exc_code_q;
        exc_pc_d       = exc_pc_q;
        commit_count_d = commit_count_q;
        discard        = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (cnt_q != '0) begin
                    if (head.exc) begin
                        // Faulting head: report it and drop every younger entry,
                        // including one accepted on this same edge.
                        exc_valid_d = 1'b1;
                        exc_code_d  = head.exc_code;
                        exc_pc_d    = head.pc;
                        state_d     = ST_FLUSH;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        cnt_d       = '0;
                        discard     = 1'b1;
                    end else begin
                        rf_we_d        = head.wen && (head.id != 5'd0);
                        rf_waddr_d     = head.id;
                        rf_wdata_d     = head.value;
                        commit_count_d = commit_count_q + 32'd1;
                        rd_ptr_d       = rd_ptr_q + c_ptr_one;
                        cnt_d          = cnt_q - c_cnt_one;
                    end
                end
                if (push && !discard) begin
                    wr_ptr_d = wr_ptr_q + c_ptr_one;
                    cnt_d    = cnt_d + c_cnt_one;
                end
            end
            ST_FLUSH: begin
                if (flush_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, pointers and registered commit outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_RUN;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= 5'd0;
            rf_wdata_q     <= 32'd0;
            exc_valid_q    <= 1'b0;
            exc_code_q     <= 5'd0;
            exc_pc_q       <= 32'd0;
            commit_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            exc_valid_q    <= exc_valid_d;
            exc_code_q     <= exc_code_d;
            exc_pc_q       <= exc_pc_d;
            commit_count_q <= commit_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commit_unit
//  Description : Self-checking bench for commit_unit; directed sequences plus
//                random traffic compared against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_target_id;
    logic [31:0] in_value;
    logic        in_wen;
    logic        in_exc;
    logic [4:0]  in_exc_code;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        flush;
    logic        flush_ack;
    logic [31:0] commit_count;

    commit_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_target_id(in_target_id), .in_value(in_value), .in_wen(in_wen),
        .in_exc(in_exc), .in_exc_code(in_exc_code),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .flush(flush), .flush_ack(flush_ack), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  id;
        logic [31:0] val;
        logic        wen;
        logic        exc;
        logic [4:0]  code;
    } ent_t;

    ent_t        mq[$];
    logic        m_flush;
    logic        m_rf_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_exc_valid;
    logic [4:0]  m_exc_code;
    logic [31:0] m_exc_pc;
    logic [31:0] m_count;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return !m_flush && (mq.size() < DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_flush = 0; m_rf_we = 0; m_waddr = 0; m_wdata = 0;
        m_exc_valid = 0; m_exc_code = 0; m_exc_pc = 0; m_count = 0;
    endtask

    // One clock edge of architectural behaviour, using the inputs held across it.
    task automatic model_edge();
        logic acc;
        logic dropped;
        ent_t h;
        acc = in_valid && model_ready();
        dropped = 0;
        m_rf_we = 0;
        m_exc_valid = 0;
        if (m_flush) begin
            if (flush_ack) m_flush = 0;
        end else begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.exc) begin
                    m_exc_valid = 1;
                    m_exc_code  = h.code;
                    m_exc_pc    = h.pc;
                    m_flush     = 1;
                    mq.delete();
                    dropped     = 1;
                end else begin
                    m_rf_we = h.wen && (h.id != 0);
                    m_waddr = h.id;
                    m_wdata = h.val;
                    m_count = m_count + 1;
                end
            end
            if (acc && !dropped)
                mq.push_back('{pc: in_pc, id: in_target_id, val: in_value,
                               wen: in_wen, exc: in_exc, code: in_exc_code});
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".rf_we"},     32'(rf_we),     32'(m_rf_we));
        check_val({tag, ".rf_waddr"},  32'(rf_waddr),  32'(m_waddr));
        check_val({tag, ".rf_wdata"},  rf_wdata,       m_wdata);
        check_val({tag, ".exc_valid"}, 32'(exc_valid), 32'(m_exc_valid));
        check_val({tag, ".exc_code"},  32'(exc_code),  32'(m_exc_code));
        check_val({tag, ".exc_pc"},    exc_pc,         m_exc_pc);
        check_val({tag, ".flush"},     32'(flush),     32'(m_flush));
        check_val({tag, ".count"},     commit_count,   m_count);
    endtask

    // Called just after a falling edge: drive, check ready, clock, check outputs.
    task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                         input logic [4:0] id, input logic [31:0] val, input logic wen,
                         input logic exc, input logic [4:0] code, input logic ack);
        in_valid = v; in_pc = pc; in_target_id = id; in_value = val;
        in_wen = wen; in_exc = exc; in_exc_code = code; flush_ack = ack;
        #1;
        check_val({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic ack);
        cycle(tag, 0, 32'd0, 5'd0, 32'd0, 0, 0, 5'd0, ack);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
    task automatic async_reset(input string tag);
        #2 resetn = 0;
        #1;
        model_reset();
        check_outputs(tag);
        check_val({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        resetn = 0;
        in_valid = 0; in_pc = 0; in_target_id = 0; in_value = 0;
        in_wen = 0; in_exc = 0; in_exc_code = 0; flush_ack = 0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        check_val("reset.in_ready", 32'(in_ready), 32'd1);

        // Single write, then write to r0 (suppressed but counted)
        cycle("single", 1, 32'h100, 5'd5, 32'hDEADBEEF, 1, 0, 5'd0, 0);
        idle("single_ret", 0);
        check_val("single.rf_we_dir", 32'(rf_we), 32'd1);
        check_val("single.count_dir", commit_count, 32'd1);
        cycle("r0", 1, 32'h104, 5'd0, 32'h1234, 1, 0, 5'd0, 0);
        idle("r0_ret", 0);
        check_val("r0.rf_we_dir", 32'(rf_we), 32'd0);
        check_val("r0.count_dir", commit_count, 32'd2);

        // Back-to-back pushes: simultaneous push/pop each cycle
        for (int i = 0; i < 6; i++)
            cycle("b2b", 1, 32'h200 + 32'(4*i), 5'(i+1), 32'(i*7+3), 1, 0, 5'd0, 0);
        idle("b2b_drain", 0);

        // A, faulting B, C: C must be discarded
        cycle("seqA", 1, 32'h200, 5'd1, 32'hAAAA, 1, 0, 5'd0, 0);
        cycle("seqB", 1, 32'h204, 5'd3, 32'hBBBB, 1, 1, 5'h0C, 0);
        cycle("seqC", 1, 32'h208, 5'd2, 32'hCCCC, 1, 0, 5'd0, 0);
        check_val("seq.exc_code_dir", 32'(exc_code), 32'h0C);
        check_val("seq.exc_pc_dir", exc_pc, 32'h204);
        for (int i = 0; i < 5; i++) cycle("flush_hold", 1, 32'h300, 5'd4, 32'h1, 1, 0, 5'd0, 0);
        idle("flush_ack", 1);
        check_val("flush_ack.in_ready_dir", 32'(in_ready), 32'd1);
        idle("run_ack_ignored", 1);

        // Counter wrap
        @(negedge clk);
        force dut.commit_count_q = 32'hFFFF_FFFF;
        #1 release dut.commit_count_q;
        m_count = 32'hFFFF_FFFF;
        @(negedge clk);
        cycle("wrap", 1, 32'h400, 5'd9, 32'h99, 1, 0, 5'd0, 0);
        idle("wrap_ret", 0);
        check_val("wrap.count_dir", commit_count, 32'd0);

        // Reset while flushing with a fault pending
        cycle("rst_fill", 1, 32'h500, 5'd6, 32'h66, 1, 1, 5'h1F, 0);
        idle("rst_fault", 0);
        async_reset("rst_mid_flush");
        idle("post_rst", 0);

        // Random traffic with occasional mid-stream resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cycle("rnd", ($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)),
                      $urandom, 1'($urandom), ($urandom_range(0, 9) == 0), 5'($urandom),
                      ($urandom_range(0, 2) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
